// File: rtl/triangle_assembler.sv
// Gathers three projected vertices into a screen-space triangle and drops clipped,
// degenerate and (optionally) back-facing ones before handing it to the rasterizer.
module triangle_assembler #(
    parameter int X_WIDTH       = 20,
    parameter int Y_WIDTH       = 18,
    parameter int Z_WIDTH       = 16,
    parameter int CULL_BACKFACE = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   vtx_valid_in,
    input  logic                   vtx_short_in,
    input  logic [X_WIDTH-1:0]     vtx_x_in,
    input  logic [Y_WIDTH-1:0]     vtx_y_in,
    input  logic [Z_WIDTH-1:0]     vtx_z_in,
    output logic                   vtx_ready_out,
    output logic                   tri_valid_out,
    input  logic                   tri_ready_in,
    output logic [3*X_WIDTH-1:0]   tri_x_out,
    output logic [3*Y_WIDTH-1:0]   tri_y_out,
    output logic [3*Z_WIDTH-1:0]   tri_z_out,
    output logic [X_WIDTH-1:0]     bbox_min_x_out,
    output logic [X_WIDTH-1:0]     bbox_max_x_out,
    output logic [Y_WIDTH-1:0]     bbox_min_y_out,
    output logic [Y_WIDTH-1:0]     bbox_max_y_out,
    output logic [CNT_WIDTH-1:0]   culled_count_out,
    output logic [2:0]             fsm_state_out
);

    // Handshakes: a vertex event is taken on an edge where vtx_ready_out is high and
    // vtx_valid_in or vtx_short_in is high; a triangle transfers on an edge where
    // tri_valid_out and tri_ready_in are both high, and tri_* hold until then.

    localparam int AW = X_WIDTH + Y_WIDTH + 3;

    typedef enum logic [2:0] {S_V0, S_V1, S_V2, S_EVAL, S_OUT} state_t;

    state_t state, state_nxt;

    logic [X_WIDTH-1:0] slot_x [3];
    logic [Y_WIDTH-1:0] slot_y [3];
    logic [Z_WIDTH-1:0] slot_z [3];
    logic               drop_q;

    logic                 slot_evt;
    logic signed [X_WIDTH:0] dx1, dx2;
    logic signed [Y_WIDTH:0] dy1, dy2;
    logic signed [AW-1:0]    prod1, prod2, area;
    logic                    cull;
    logic [X_WIDTH-1:0]      min_x, max_x;
    logic [Y_WIDTH-1:0]      min_y, max_y;

    assign slot_evt      = vtx_ready_out && (vtx_valid_in || vtx_short_in);
    assign fsm_state_out = state;

    // Edge vectors relative to vertex 0; products are widened so nothing truncates.
    always_comb begin
        dx1   = $signed({1'b0, slot_x[1]}) - $signed({1'b0, slot_x[0]});
        dx2   = $signed({1'b0, slot_x[2]}) - $signed({1'b0, slot_x[0]});
        dy1   = $signed({1'b0, slot_y[1]}) - $signed({1'b0, slot_y[0]});
        dy2   = $signed({1'b0, slot_y[2]}) - $signed({1'b0, slot_y[0]});
        prod1 = AW'(dx1) * AW'(dy2);
        prod2 = AW'(dx2) * AW'(dy1);
        area  = prod1 - prod2;
        cull  = drop_q || (area == '0) || ((CULL_BACKFACE != 0) && area[AW-1]);
    end

    always_comb begin
        min_x = slot_x[0];
        max_x = slot_x[0];
        min_y = slot_y[0];
        max_y = slot_y[0];
        for (int i = 1; i < 3; i++) begin
            if (slot_x[i] < min_x) min_x = slot_x[i];
            if (slot_x[i] > max_x) max_x = slot_x[i];
            if (slot_y[i] < min_y) min_y = slot_y[i];
            if (slot_y[i] > max_y) max_y = slot_y[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_V0:    if (slot_evt) state_nxt = S_V1;
            S_V1:    if (slot_evt) state_nxt = S_V2;
            S_V2:    if (slot_evt) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = cull ? S_V0 : S_OUT;
            S_OUT:   if (tri_ready_in) state_nxt = S_V0;
            default: state_nxt = S_V0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= S_V0;
            vtx_ready_out    <= 1'b0;
            tri_valid_out    <= 1'b0;
            drop_q           <= 1'b0;
            tri_x_out        <= '0;
            tri_y_out        <= '0;
            tri_z_out        <= '0;
            bbox_min_x_out   <= '0;
            bbox_max_x_out   <= '0;
            bbox_min_y_out   <= '0;
            bbox_max_y_out   <= '0;
            culled_count_out <= '0;
            for (int i = 0; i < 3; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
                slot_z[i] <= '0;
            end
        end else begin
            state         <= state_nxt;
            vtx_ready_out <= (state_nxt == S_V0) || (state_nxt == S_V1) || (state_nxt == S_V2);

            // A short pulse only poisons the triangle; it still consumes a slot.
            if (slot_evt) begin
                if (vtx_short_in) begin
                    drop_q <= 1'b1;
                end else begin
                    case (state)
                        S_V0: begin
                            slot_x[0] <= vtx_x_in; slot_y[0] <= vtx_y_in; slot_z[0] <= vtx_z_in;
                        end
                        S_V1: begin
                            slot_x[1] <= vtx_x_in; slot_y[1] <= vtx_y_in; slot_z[1] <= vtx_z_in;
                        end
                        S_V2: begin
                            slot_x[2] <= vtx_x_in; slot_y[2] <= vtx_y_in; slot_z[2] <= vtx_z_in;
                        end
                        default: ;
                    endcase
                end
            end

            if (state == S_EVAL) begin
                if (cull) begin
                    culled_count_out <= culled_count_out + 1'b1;
                    drop_q           <= 1'b0;
                end else begin
                    tri_x_out      <= {slot_x[2], slot_x[1], slot_x[0]};
                    tri_y_out      <= {slot_y[2], slot_y[1], slot_y[0]};
                    tri_z_out      <= {slot_z[2], slot_z[1], slot_z[0]};
                    bbox_min_x_out <= min_x;
                    bbox_max_x_out <= max_x;
                    bbox_min_y_out <= min_y;
                    bbox_max_y_out <= max_y;
                    tri_valid_out  <= 1'b1;
                end
            end

            if ((state == S_OUT) && tri_ready_in) tri_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_triangle_assembler.sv
// Scoreboard bench for triangle_assembler: a reference model predicts each surviving
// triangle and the culled count; the output monitor pops and compares on each transfer.
module tb_triangle_assembler;

    localparam int XW = 20;
    localparam int YW = 18;
    localparam int ZW = 16;
    localparam int CW = 16;
    localparam int W  = 5*XW + 5*YW + 3*ZW;
    localparam int MX = (1 << XW) - 1;
    localparam int MY = (1 << YW) - 1;

    logic            clk;
    logic            rst_n;
    logic            vtx_valid;
    logic            vtx_short;
    logic [XW-1:0]   vtx_x;
    logic [YW-1:0]   vtx_y;
    logic [ZW-1:0]   vtx_z;
    logic            vtx_ready_out;
    logic            tri_valid_out;
    logic            tri_ready;
    logic [3*XW-1:0] tri_x_out;
    logic [3*YW-1:0] tri_y_out;
    logic [3*ZW-1:0] tri_z_out;
    logic [XW-1:0]   bbox_min_x_out, bbox_max_x_out;
    logic [YW-1:0]   bbox_min_y_out, bbox_max_y_out;
    logic [CW-1:0]   culled_count_out;
    logic [2:0]      fsm_state_out;
    logic [W-1:0]    obs;

    int n_checks = 0;
    int n_errors = 0;
    int exp_culled = 0;
    logic [W-1:0] exp_q[$];

    triangle_assembler #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .Z_WIDTH(ZW), .CULL_BACKFACE(1), .CNT_WIDTH(CW)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .vtx_valid_in(vtx_valid),
        .vtx_short_in(vtx_short),
        .vtx_x_in(vtx_x),
        .vtx_y_in(vtx_y),
        .vtx_z_in(vtx_z),
        .vtx_ready_out(vtx_ready_out),
        .tri_valid_out(tri_valid_out),
        .tri_ready_in(tri_ready),
        .tri_x_out(tri_x_out),
        .tri_y_out(tri_y_out),
        .tri_z_out(tri_z_out),
        .bbox_min_x_out(bbox_min_x_out),
        .bbox_max_x_out(bbox_max_x_out),
        .bbox_min_y_out(bbox_min_y_out),
        .bbox_max_y_out(bbox_max_y_out),
        .culled_count_out(culled_count_out),
        .fsm_state_out(fsm_state_out)
    );

    assign obs = {tri_x_out, tri_y_out, tri_z_out,
                  bbox_min_x_out, bbox_max_x_out, bbox_min_y_out, bbox_max_y_out};

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // output monitor: every transfer must match the oldest predicted triangle
    always @(negedge clk) begin
        if (rst_n && tri_valid_out && tri_ready) begin
            check_eq("tri_expected_pending", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) check_eq("tri_data", obs, exp_q.pop_front());
        end
    end

    // driver: call at a negedge; returns at the negedge after the event is sampled
    task automatic send_vtx(input int x, input int y, input int z, input logic sh);
        int guard = 0;
        while (!vtx_ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!vtx_ready_out) check_eq("vtx_ready_timeout", W'(vtx_ready_out), W'(1));
        vtx_valid = !sh || ($urandom_range(0, 1) == 1);
        vtx_short = sh;
        vtx_x     = XW'(x);
        vtx_y     = YW'(y);
        vtx_z     = ZW'(z);
        @(negedge clk);
        vtx_valid = 1'b0;
        vtx_short = 1'b0;
    endtask

    task automatic do_tri(input int ax, input int ay, input int az,
                          input int bx, input int by, input int bz,
                          input int cx, input int cy, input int cz,
                          input logic [2:0] sh);
        longint area;
        area = longint'(bx - ax) * longint'(cy - ay) - longint'(cx - ax) * longint'(by - ay);
        if (sh == 3'b000 && area > 0)
            exp_q.push_back({XW'(cx), XW'(bx), XW'(ax), YW'(cy), YW'(by), YW'(ay),
                             ZW'(cz), ZW'(bz), ZW'(az),
                             XW'(min3(ax, bx, cx)), XW'(max3(ax, bx, cx)),
                             YW'(min3(ay, by, cy)), YW'(max3(ay, by, cy))});
        else
            exp_culled++;
        send_vtx(ax, ay, az, sh[0]);
        send_vtx(bx, by, bz, sh[1]);
        send_vtx(cx, cy, cz, sh[2]);
    endtask

    task automatic settle(input string tag);
        int guard = 0;
        while (!(vtx_ready_out && !tri_valid_out) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_idle_ready"}, W'(vtx_ready_out), W'(1));
        check_eq({tag, "_queue_empty"}, W'(exp_q.size()), W'(0));
        check_eq({tag, "_culled"}, W'(culled_count_out), W'(CW'(exp_culled)));
    endtask

    task automatic set_tri_ready(input logic v);
        @(posedge clk);
        #1 tri_ready = v;
        @(negedge clk);
    endtask

    task automatic wait_tri_valid(input string tag);
        int guard = 0;
        while (!tri_valid_out && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_valid_rise"}, W'(tri_valid_out), W'(1));
    endtask

    task automatic clear_model();
        exp_culled = 0;
        exp_q.delete();
    endtask

    initial begin
        logic [2:0] sh;
        rst_n = 1'b0; vtx_valid = 1'b0; vtx_short = 1'b0; tri_ready = 1'b1;
        vtx_x = '0; vtx_y = '0; vtx_z = '0;

        // reset state
        #12;
        check_eq("rst_ready", W'(vtx_ready_out), W'(0));
        check_eq("rst_valid", W'(tri_valid_out), W'(0));
        check_eq("rst_count", W'(culled_count_out), W'(0));
        check_eq("rst_outputs", obs, W'(0));
        check_eq("rst_state", W'(fsm_state_out), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #2 check_eq("ready_before_edge", W'(vtx_ready_out), W'(0));
        @(negedge clk);
        check_eq("ready_after_edge", W'(vtx_ready_out), W'(1));

        // CCW triangle with latency check
        do_tri(10, 10, 5, 30, 10, 6, 10, 40, 7, 3'b000);
        check_eq("eval_valid_low", W'(tri_valid_out), W'(0));
        check_eq("eval_ready_low", W'(vtx_ready_out), W'(0));
        check_eq("eval_state", W'(fsm_state_out), W'(3));
        @(negedge clk);
        check_eq("lat_valid_high", W'(tri_valid_out), W'(1));
        settle("t1");

        // CW winding is back-facing
        do_tri(10, 10, 5, 10, 40, 7, 30, 10, 6, 3'b000);
        check_eq("cw_ready_low", W'(vtx_ready_out), W'(0));
        @(negedge clk);
        check_eq("cw_ready_back", W'(vtx_ready_out), W'(1));
        settle("t2");

        // short as second vertex, then a clean triangle
        do_tri(10, 10, 1, 30, 10, 2, 10, 40, 3, 3'b010);
        do_tri(100, 200, 9, 400, 220, 8, 150, 900, 7, 3'b000);
        settle("t3");

        // collinear
        do_tri(0, 0, 0, 5, 5, 0, 10, 10, 0, 3'b000);
        do_tri(10, 10, 0, 0, 0, 0, 5, 5, 0, 3'b000);
        settle("t4");

        // rasterizer stall with ignored vertex traffic
        set_tri_ready(1'b0);
        do_tri(50, 60, 11, 90, 60, 12, 70, 100, 13, 3'b000);
        wait_tri_valid("stall");
        for (int i = 0; i < 20; i++) begin
            vtx_valid = 1'b1;
            vtx_short = (i % 3 == 0);
            vtx_x = XW'($urandom_range(0, MX));
            vtx_y = YW'($urandom_range(0, MY));
            @(negedge clk);
            check_eq("stall_obs", obs, exp_q[0]);
            check_eq("stall_ready", W'(vtx_ready_out), W'(0));
            check_eq("stall_valid", W'(tri_valid_out), W'(1));
        end
        vtx_valid = 1'b0; vtx_short = 1'b0;
        set_tri_ready(1'b1);
        settle("t5a");
        do_tri(5, 5, 1, 25, 5, 2, 5, 25, 3, 3'b000);
        settle("t5b");

        // async reset mid-V1
        send_vtx(1, 1, 1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstv1_ready", W'(vtx_ready_out), W'(0));
        check_eq("rstv1_count", W'(culled_count_out), W'(0));
        check_eq("rstv1_state", W'(fsm_state_out), W'(0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_tri(200, 300, 4, 260, 310, 5, 210, 390, 6, 3'b000);
        settle("t6a");

        // async reset mid-OUT
        set_tri_ready(1'b0);
        do_tri(1, 1, 1, 9, 1, 1, 1, 9, 1, 3'b000);
        wait_tri_valid("rstout");
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstout_valid", W'(tri_valid_out), W'(0));
        check_eq("rstout_outputs", obs, W'(0));
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        tri_ready = 1'b1;
        @(negedge clk);
        do_tri(7, 3, 2, 70, 8, 3, 20, 60, 4, 3'b000);
        settle("t6b");

        // full-range coordinates, both windings
        do_tri(0, 0, 0, MX, 0, 1, 0, MY, 2, 3'b000);
        do_tri(0, 0, 0, 0, MY, 2, MX, 0, 1, 3'b000);
        do_tri(MX, MY, 3, 0, MY, 4, MX, 0, 5, 3'b000);
        do_tri(MX, MY, 3, MX, 0, 5, 0, MY, 4, 3'b000);
        settle("corner");

        // random back-to-back triangles with occasional clipped vertices
        for (int t = 0; t < 12; t++) begin
            sh = ($urandom_range(0, 3) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            do_tri($urandom_range(0, MX), $urandom_range(0, MY), $urandom_range(0, 65535),
                   $urandom_range(0, MX), $urandom_range(0, MY), $urandom_range(0, 65535),
                   $urandom_range(0, MX), $urandom_range(0, MY), $urandom_range(0, 65535),
                   sh);
        end
        settle("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
